// File: rtl/rf_sched_pkg.sv
// Shared types and geometry for the register-file port scheduler.
package rf_sched_pkg;

  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_PW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/rf_port_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping round.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [N-1:0] pick;

  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    masked = req & mask;
    // Nothing at or above the pointer: wrap round to the lowest requester.
    pick  = (|masked) ? masked : req;
    grant = pick & (~pick + N'(1));
  end

endmodule

// File: rtl/rf_port_sched.sv
// Write-port arbitration and snapshot scan in front of the 32x32 tagged register file.
module rf_port_sched
  import rf_sched_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter bit PROTECT_R0  = 1'b1,
  parameter bit SCAN_FREEZE = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [RF_AW*NUM_REQ-1:0] req_addr_i,
  input  logic [RF_DW*NUM_REQ-1:0] req_data_i,
  input  logic [RF_PW*NUM_REQ-1:0] req_pos_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     rf_we_o,
  output logic [RF_AW-1:0]         rf_waddr_o,
  output logic [RF_DW-1:0]         rf_wdata_o,
  output logic [RF_PW-1:0]         rf_pos_o,
  output logic [RF_AW-1:0]         rf_op_addr_o,
  input  logic [RF_DW-1:0]         rf_reg_i,
  input  logic [RF_PW-1:0]         rf_pos_i,
  input  logic                     scan_start_i,
  output logic                     scan_valid_o,
  input  logic                     scan_ready_i,
  output logic [RF_AW-1:0]         scan_addr_o,
  output logic [RF_DW-1:0]         scan_data_o,
  output logic [RF_PW-1:0]         scan_pos_o,
  output logic                     scan_busy_o,
  output logic                     scan_done_o,
  output logic [5:0]               scan_tagcnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  scan_state_e        state;
  logic [5:0]         cnt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic               freeze;
  logic               xfer;
  logic [PTR_W-1:0]   g_idx;
  logic [RF_AW-1:0]   g_addr;
  logic [RF_DW-1:0]   g_data;
  logic [RF_PW-1:0]   g_pos;

  rr_arbiter #(.N(NUM_REQ), .PW(PTR_W)) u_arb (
    .req   (req_valid_i),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign freeze      = SCAN_FREEZE && (state != ST_IDLE);
  assign req_ready_o = (reset_n && !freeze) ? grant : '0;
  assign xfer        = |req_ready_o;

  always_comb begin
    g_idx  = '0;
    g_addr = '0;
    g_data = '0;
    g_pos  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_ready_o[k]) begin
        g_idx  = PTR_W'(k);
        g_addr = req_addr_i[k*RF_AW +: RF_AW];
        g_data = req_data_i[k*RF_DW +: RF_DW];
        g_pos  = req_pos_i[k*RF_PW +: RF_PW];
      end
    end
  end

  assign ptr_next = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr     <= '0;
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      rf_pos_o   <= '0;
    end else begin
      // A protected r0 write is still acknowledged; it just never reaches the file.
      rf_we_o <= xfer && !(PROTECT_R0 && (g_addr == '0));
      if (xfer) begin
        rr_ptr     <= ptr_next;
        rf_waddr_o <= g_addr;
        rf_wdata_o <= g_data;
        rf_pos_o   <= g_pos;
      end
    end
  end

  assign rf_op_addr_o = (state == ST_SCAN) ? cnt[RF_AW-1:0] : '0;
  assign scan_busy_o  = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      scan_valid_o  <= 1'b0;
      scan_addr_o   <= '0;
      scan_data_o   <= '0;
      scan_pos_o    <= '0;
      scan_done_o   <= 1'b0;
      scan_tagcnt_o <= '0;
    end else begin
      scan_done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (scan_start_i) begin
            state         <= ST_SCAN;
            cnt           <= '0;
            scan_tagcnt_o <= '0;
          end
        end
        ST_SCAN: begin
          // Capture a new beat whenever the output slot is empty or being drained.
          if (!scan_valid_o || scan_ready_i) begin
            scan_valid_o <= 1'b1;
            scan_addr_o  <= cnt[RF_AW-1:0];
            scan_data_o  <= rf_reg_i;
            scan_pos_o   <= rf_pos_i;
            if (rf_pos_i != '0) scan_tagcnt_o <= scan_tagcnt_o + 6'd1;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(RF_DEPTH - 1)) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (scan_ready_i) begin
            scan_valid_o <= 1'b0;
            scan_done_o  <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_port_sched.sv
// Directed bench: arbitration table, protected r0, snapshot scans with stall, freeze and abort.
module tb_rf_port_sched;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [11:0] req_pos;
  logic        scan_start;
  logic        scan_ready;

  logic [2:0]  req_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [3:0]  rf_pos_o;
  logic [4:0]  rf_op_addr_o;
  logic [31:0] rf_reg;
  logic [3:0]  rf_tag_rd;
  logic        scan_valid_o;
  logic [4:0]  scan_addr_o;
  logic [31:0] scan_data_o;
  logic [3:0]  scan_pos_o;
  logic        scan_busy_o;
  logic        scan_done_o;
  logic [5:0]  scan_tagcnt_o;

  logic [2:0]  b_ready;
  logic        b_we;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [3:0]  b_pos;
  logic [4:0]  b_op_addr;
  logic        b_scan_valid;
  logic [4:0]  b_scan_addr;
  logic [31:0] b_scan_data;
  logic [3:0]  b_scan_pos;
  logic        b_scan_busy;
  logic        b_scan_done;
  logic [5:0]  b_scan_tagcnt;

  logic [31:0] rf_mem [32];
  logic [3:0]  rf_tag [32];
  logic        mem_init = 1'b1;
  logic [31:0] exp_mem [32];
  logic [3:0]  exp_tag [32];

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  rf_port_sched #(.NUM_REQ(3), .PROTECT_R0(1'b1), .SCAN_FREEZE(1'b1)) dut (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data), .req_pos_i(req_pos),
    .req_ready_o(req_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_pos_o(rf_pos_o),
    .rf_op_addr_o(rf_op_addr_o), .rf_reg_i(rf_reg), .rf_pos_i(rf_tag_rd),
    .scan_start_i(scan_start), .scan_valid_o(scan_valid_o), .scan_ready_i(scan_ready),
    .scan_addr_o(scan_addr_o), .scan_data_o(scan_data_o), .scan_pos_o(scan_pos_o),
    .scan_busy_o(scan_busy_o), .scan_done_o(scan_done_o), .scan_tagcnt_o(scan_tagcnt_o)
  );

  // Second instance with r0 unprotected; shares the requesters but never scans.
  rf_port_sched #(.NUM_REQ(3), .PROTECT_R0(1'b0), .SCAN_FREEZE(1'b0)) dut_b (
    .clk_i(clk_i), .reset_n(reset_n),
    .req_valid_i(req_valid), .req_addr_i(req_addr), .req_data_i(req_data), .req_pos_i(req_pos),
    .req_ready_o(b_ready),
    .rf_we_o(b_we), .rf_waddr_o(b_waddr), .rf_wdata_o(b_wdata), .rf_pos_o(b_pos),
    .rf_op_addr_o(b_op_addr), .rf_reg_i(32'h0), .rf_pos_i(4'h0),
    .scan_start_i(1'b0), .scan_valid_o(b_scan_valid), .scan_ready_i(1'b1),
    .scan_addr_o(b_scan_addr), .scan_data_o(b_scan_data), .scan_pos_o(b_scan_pos),
    .scan_busy_o(b_scan_busy), .scan_done_o(b_scan_done), .scan_tagcnt_o(b_scan_tagcnt)
  );

  // Register file model: writes land on the negedge after the registered write port.
  always @(negedge clk_i) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) begin
        rf_mem[i] <= '0;
        rf_tag[i] <= '0;
      end
      mem_init <= 1'b0;
    end else if (rf_we_o) begin
      rf_mem[rf_waddr_o] <= rf_wdata_o;
      rf_tag[rf_waddr_o] <= rf_pos_o;
    end
  end

  assign rf_reg    = rf_mem[rf_op_addr_o];
  assign rf_tag_rd = rf_tag[rf_op_addr_o];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d, input logic [3:0] p);
    int waited = 0;
    req_valid = '0;
    req_valid[k] = 1'b1;
    req_addr[k*5 +: 5]   = a;
    req_data[k*32 +: 32] = d;
    req_pos[k*4 +: 4]    = p;
    #1;
    while (!req_ready_o[k] && waited < 10) begin
      step();
      waited++;
    end
    check("wr_ready", req_ready_o[k], 1);
    step();
    req_valid = '0;
    check("wr_we", rf_we_o, (a != 5'd0));
    if (a != 5'd0) begin
      exp_mem[a] = d;
      exp_tag[a] = p;
    end
  endtask

  task automatic run_scan(input string tag, input int stall_at, input int abort_at, input bit freeze_chk);
    int beats = 0, order_err = 0, data_err = 0, hold_err = 0, frz_err = 0, stall = 0;
    bit got_done = 1'b0;
    logic [31:0] h_data = '0;
    scan_start = 1'b1;
    scan_ready = 1'b1;
    step();
    scan_start = 1'b0;
    check({tag, "_busy"}, scan_busy_o, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (scan_done_o) begin
        got_done = 1'b1;
        break;
      end
      if (freeze_chk && scan_busy_o && req_ready_o != 3'b000) frz_err++;
      if (abort_at >= 0 && scan_valid_o && scan_addr_o == 5'(abort_at)) return;
      if (stall_at >= 0 && scan_valid_o && scan_addr_o == 5'(stall_at) && stall < 4) begin
        if (stall == 0) h_data = scan_data_o;
        else if (scan_data_o != h_data) hold_err++;
        stall++;
        scan_ready = 1'b0;
      end else begin
        scan_ready = 1'b1;
      end
      if (scan_valid_o && scan_ready) begin
        if (beats > 31 || scan_addr_o != 5'(beats)) order_err++;
        else if (scan_data_o != exp_mem[beats] || scan_pos_o != exp_tag[beats]) data_err++;
        beats++;
      end
      step();
    end
    check({tag, "_done_seen"}, got_done, 1);
    check({tag, "_beats"}, beats, 32);
    check({tag, "_order_err"}, order_err, 0);
    check({tag, "_data_err"}, data_err, 0);
    check({tag, "_tagcnt"}, scan_tagcnt_o, 2);
    check({tag, "_busy_end"}, scan_busy_o, 0);
    if (stall_at >= 0) begin
      check({tag, "_stall_cycles"}, stall, 4);
      check({tag, "_hold_err"}, hold_err, 0);
    end
    if (freeze_chk) begin
      check({tag, "_frz_err"}, frz_err, 0);
      check({tag, "_ready_after"}, req_ready_o, 3'b001);
    end
    step();
    check({tag, "_done_single"}, scan_done_o, 0);
    if (freeze_chk) begin
      check({tag, "_post_we"}, rf_we_o, 1);
      check({tag, "_post_waddr"}, rf_waddr_o, 5'd2);
    end
  endtask

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [2:0]  ready;
    logic        we;
    logic        we_b;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } vec_t;

  localparam logic [14:0] ADDR_A = {5'd3, 5'd2, 5'd1};
  localparam logic [14:0] ADDR_B = {5'd3, 5'd0, 5'd1};
  localparam logic [31:0] D0 = 32'h1111_1111;
  localparam logic [31:0] D1 = 32'hDEAD_BEEF;
  localparam logic [31:0] D2 = 32'h3333_3333;

  vec_t vecs [11];
  int   dones;

  initial begin
    vecs[0]  = '{3'b111, ADDR_A, 3'b001, 1'b1, 1'b1, 5'd1, D0};
    vecs[1]  = '{3'b111, ADDR_A, 3'b010, 1'b1, 1'b1, 5'd2, D1};
    vecs[2]  = '{3'b111, ADDR_A, 3'b100, 1'b1, 1'b1, 5'd3, D2};
    vecs[3]  = '{3'b111, ADDR_A, 3'b001, 1'b1, 1'b1, 5'd1, D0};
    vecs[4]  = '{3'b111, ADDR_A, 3'b010, 1'b1, 1'b1, 5'd2, D1};
    vecs[5]  = '{3'b111, ADDR_A, 3'b100, 1'b1, 1'b1, 5'd3, D2};
    vecs[6]  = '{3'b000, ADDR_A, 3'b000, 1'b0, 1'b0, 5'd3, D2};
    vecs[7]  = '{3'b110, ADDR_A, 3'b010, 1'b1, 1'b1, 5'd2, D1};
    vecs[8]  = '{3'b011, ADDR_A, 3'b001, 1'b1, 1'b1, 5'd1, D0};
    vecs[9]  = '{3'b010, ADDR_B, 3'b010, 1'b0, 1'b1, 5'd0, D1};
    vecs[10] = '{3'b101, ADDR_A, 3'b100, 1'b1, 1'b1, 5'd3, D2};

    for (int i = 0; i < 32; i++) begin
      exp_mem[i] = '0;
      exp_tag[i] = '0;
    end

    reset_n    = 1'b0;
    req_valid  = 3'b111;
    req_addr   = ADDR_A;
    req_data   = {D2, D1, D0};
    req_pos    = '0;
    scan_start = 1'b0;
    scan_ready = 1'b1;
    #1;
    check("rst_ready", req_ready_o, 3'b000);
    check("rst_we", rf_we_o, 0);
    check("rst_scan_valid", scan_valid_o, 0);
    check("rst_busy", scan_busy_o, 0);
    check("rst_op_addr", rf_op_addr_o, 0);
    check("rst_tagcnt", scan_tagcnt_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req_valid = vecs[i].valid;
      req_addr  = vecs[i].addr;
      #1;
      check($sformatf("v%0d_ready", i), req_ready_o, vecs[i].ready);
      step();
      check($sformatf("v%0d_we", i), rf_we_o, vecs[i].we);
      check($sformatf("v%0d_waddr", i), rf_waddr_o, vecs[i].waddr);
      check($sformatf("v%0d_wdata", i), rf_wdata_o, vecs[i].wdata);
      check($sformatf("v%0d_we_b", i), b_we, vecs[i].we_b);
      check($sformatf("v%0d_waddr_b", i), b_waddr, vecs[i].waddr);
      check($sformatf("v%0d_wdata_b", i), b_wdata, vecs[i].wdata);
      if (vecs[i].we) begin
        exp_mem[vecs[i].waddr] = vecs[i].wdata;
        exp_tag[vecs[i].waddr] = 4'h0;
      end
    end
    req_valid = '0;
    req_addr  = ADDR_A;

    wr(0, 5'd5, 32'h5555_0005, 4'd3);
    wr(2, 5'd9, 32'h9999_0009, 4'd1);
    step();

    run_scan("scan1", -1, -1, 1'b0);

    // Write to r2 on the start edge, then keep requester 0 pending across the frozen scan.
    req_valid = 3'b001;
    req_addr[4:0]  = 5'd2;
    req_data[31:0] = 32'h2222_AAAA;
    req_pos[3:0]   = 4'd0;
    exp_mem[2] = 32'h2222_AAAA;
    exp_tag[2] = 4'd0;
    run_scan("scan2", 10, -1, 1'b1);
    req_valid = '0;
    step();

    run_scan("scan3", -1, 12, 1'b0);
    check("abort_at_beat", scan_addr_o, 5'd12);
    req_valid = 3'b001;
    reset_n = 1'b0;
    #1;
    check("abort_scan_valid", scan_valid_o, 0);
    check("abort_scan_addr", scan_addr_o, 0);
    check("abort_scan_data", scan_data_o, 0);
    check("abort_busy", scan_busy_o, 0);
    check("abort_tagcnt", scan_tagcnt_o, 0);
    check("abort_op_addr", rf_op_addr_o, 0);
    check("abort_wdata", rf_wdata_o, 0);
    check("abort_ready", req_ready_o, 3'b000);
    dones = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (scan_done_o) dones++;
    end
    req_valid = '0;
    reset_n = 1'b1;
    step();
    if (scan_done_o) dones++;
    check("abort_no_done", dones, 0);

    run_scan("scan4", -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_port_sched.md
Name: rf_port_sched

Overview:
- Scheduler that sits in front of the 32x32 register file (32-bit data plus a 4-bit position tag per entry).
- Shares the file's single write port among NUM_REQ requesters (e.g. writeback, fault-injection, debug) using round-robin valid/ready arbitration.
- Owns the file's op_address read port and runs a snapshot scan: all 32 entries (data + tag) are streamed out on request, with a count of entries whose tag is non-zero.

Parameters:
- NUM_REQ, 3, number of write requesters (2..8).
- PROTECT_R0, 1, when 1 a write to address 0 is acknowledged but not forwarded (rf_we_o stays 0).
- SCAN_FREEZE, 1, when 1 all write grants are blocked while the scan FSM is not IDLE.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester write request.
- req_addr_i  in  5*NUM_REQ  packed destination addresses; requester k uses bits [5k+4:5k].
- req_data_i  in  32*NUM_REQ  packed write data.
- req_pos_i  in  4*NUM_REQ  packed position tags.
- req_ready_o  out  NUM_REQ  one-hot grant; combinational from valid, rr pointer and freeze.
- rf_we_o  out  1  register-file write enable (RegWrite).
- rf_waddr_o  out  5  register-file write address.
- rf_wdata_o  out  32  register-file write data.
- rf_pos_o  out  4  register-file tag input.
- rf_op_addr_o  out  5  register-file read address (op_address).
- rf_reg_i  in  32  register-file read data at rf_op_addr_o.
- rf_pos_i  in  4  register-file tag at rf_op_addr_o.
- scan_start_i  in  1  single-cycle scan request.
- scan_valid_o  out  1  scan beat valid.
- scan_ready_i  in  1  scan beat accepted.
- scan_addr_o  out  5  address of the current beat.
- scan_data_o  out  32  data of the current beat.
- scan_pos_o  out  4  tag of the current beat.
- scan_busy_o  out  1  high while the FSM is not IDLE.
- scan_done_o  out  1  one-cycle pulse at scan end.
- scan_tagcnt_o  out  6  count of scanned entries with non-zero tag; valid when scan_done_o pulses and held until the next scan starts.

Behaviour:
- Reset (reset_n=0, asynchronous): every output register is 0, rr pointer is 0, FSM is IDLE; req_ready_o is 0 while reset is asserted.
- Arbitration:
  - Candidates are all k with req_valid_i[k]=1. The grant goes to the first candidate at or after the rr pointer, wrapping round.
  - req_ready_o is 0 for all requesters when SCAN_FREEZE=1 and the FSM is not IDLE.
  - A transfer happens on a posedge when valid and ready are both 1. On that edge the rr pointer becomes (granted index+1) mod NUM_REQ.
  - rf_we/waddr/wdata/pos are registered from the transfer, so they are valid the cycle after it. The file writes them on the following negedge, giving a visible latency of 1 cycle.
  - rf_we_o is 0 on any cycle with no transfer. It is also 0 when PROTECT_R0=1 and the address is 0; that request is still acknowledged.
- Scan FSM, states IDLE -> SCAN -> DONE -> IDLE:
  - IDLE: rf_op_addr_o=0 and scan_busy_o=0. scan_start_i moves the FSM to SCAN, clears the scan counter and clears scan_tagcnt_o.
  - SCAN: rf_op_addr_o is the counter. When scan_valid_o=0 or scan_ready_i=1:
    - capture rf_reg_i, rf_pos_i and the counter into the scan outputs and set scan_valid_o=1;
    - add 1 to scan_tagcnt_o if rf_pos_i is non-zero;
    - increment the counter.
  - SCAN exit: after address 31 is captured, go to DONE.
  - Back-pressure: while scan_valid_o=1 and scan_ready_i=0, the beat outputs and the counter hold.
  - DONE: waits for the final beat to be accepted, then clears scan_valid_o, pulses scan_done_o for one cycle and returns to IDLE.
  - scan_start_i is ignored outside IDLE.
- Simultaneous events:
  - A transfer on the same edge as scan_start_i is still completed; it lands before the first beat is sampled.
  - With SCAN_FREEZE=0, the sampled data reflects every write landed by the sampling edge.
- Reset during a scan aborts it immediately: outputs go to 0 and no scan_done_o pulse is produced.
- Width rules: the counter is 6 bits internally (0..32), and its low 5 bits drive rf_op_addr_o. scan_tagcnt_o is at most 32 and never saturates.

Decomposition:
- Shared package rf_sched_pkg:
  - scan state enum (IDLE/SCAN/DONE);
  - constants RF_DEPTH=32, RF_AW=5, RF_DW=32, RF_PW=4.
- One sub-module, rr_arbiter: parameterised round-robin, with inputs req and pointer and a one-hot grant output.
- Scan FSM and write-port registers are in the top level.

Test Plan:
- NUM_REQ=3, all valid continuously, each with distinct addr (1, 2, 3) -> grants follow 0,1,2,0,1,2. rf_waddr_o follows 1,2,3,... one cycle after each grant, with rf_we_o high every cycle.
- Requester 1 writes addr 0 with data 0xDEADBEEF, PROTECT_R0=1 -> req_ready_o[1]=1 and rf_we_o=0. Then addr 0 with PROTECT_R0=0 -> rf_we_o=1, rf_waddr_o=0.
- Preload r5 tag=3 and r9 tag=1, then pulse scan_start_i with scan_ready_i=1 -> 32 beats with addr 0..31 in order, beat 5 has pos 3, scan_done_o pulses once, scan_tagcnt_o=2.
- During the scan, hold scan_ready_i=0 for 4 cycles at beat 10 -> beat 10 holds stable, with no skipped or duplicated addresses.
- SCAN_FREEZE=1, requester 0 valid throughout the scan -> req_ready_o=0 during SCAN and DONE, and the transfer occurs the cycle after return to IDLE.
- Drop reset_n at beat 12 -> all outputs go to 0 asynchronously, with no done pulse. After release a new scan completes all 32 beats.
